serial_half_subtractor: RTL and testbench
=========================================

Name: serial_half_subtractor

Overview:
- Bit-serial subtractor: the inverse operation to the team's combinational half-adder tile.
- Accepts two W-bit operands over a valid/ready handshake. Computes A − B LSB-first, one bit per clock, through a single full-subtractor cell with a registered borrow.
- Presents the difference and final borrow over a second valid/ready handshake.
- Sits behind the tile's dedicated-input mux as the sequential arithmetic demo; trades W cycles of latency for one-bit datapath area.

Parameters:
- W, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operands a, b are valid this cycle.
- in_ready  out  1  block can accept operands (high only in IDLE).
- a  in  W  minuend.
- b  in  W  subtrahend.
- out_valid  out  1  diff and borrow_out are valid (high only in DONE).
- out_ready  in  1  consumer accepts the result.
- diff  out  W  (a − b) mod 2^W.
- borrow_out  out  1  1 when a < b, unsigned.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE; internal shift registers, counter and borrow cleared.
  - Outputs: in_ready=1, out_valid=0, diff=0, borrow_out=0.
  - Reset at any time, including mid-RUN or in DONE, aborts the operation; no result is produced.
- States:
  - IDLE: in_ready=1. On in_valid=1, latch a→sa and b→sb, clear borrow, count=0, diff register=0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle:
    - d = sa[0] ^ sb[0] ^ br
    - br' = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br)
    - diff register shifts right with d entering at bit W−1; sa and sb shift right.
    - count increments. When count==W−1 this cycle, go to DONE.
  - DONE: out_valid=1; diff and borrow_out hold stable. On out_ready=1, go to IDLE.
- Latency: operand accepted at edge t0 → out_valid first high in the cycle after edge t0+W. For W=8, out_valid is high in cycle 9 relative to the accept cycle 0.
- Throughput: one operation per W+2 cycles minimum. There is no same-cycle turnaround: in_ready is 0 in DONE even while out_ready=1.
- Inputs ignored outside their states:
  - in_valid outside IDLE.
  - a and b except at the accept edge; later changes do not affect the result.
  - out_ready outside DONE.
- Backpressure: DONE holds indefinitely while out_ready=0; outputs do not change.
- Output values:
  - diff and borrow_out read 0 in IDLE and RUN.
  - The diff and borrow registers drive the outputs directly in DONE; no combinational path exists from inputs to outputs.
  - borrow_out equals br after the final RUN step.
- Arithmetic is unsigned modulo 2^W. Boundary cases:
  - a==b gives diff=0, borrow=0.
  - a=0, b=2^W−1 gives diff=1, borrow=1.
- Counter width is $clog2(W) bits. The counter never wraps in use, because count==W−1 forces exit from RUN.

Decomposition:
- Shared package:
  - state enum: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - localparam for counter width.
- One natural sub-module: full_subtractor_cell (combinational: a_bit, b_bit, bin → d, bout), reused by the future serial adder variant.
- The FSM, counter and shift registers stay in the top block.

Test Plan:
- W=8, a=5, b=3, in_valid for 1 cycle, out_ready=1 → out_valid high exactly 9 cycles after accept; diff=0x02, borrow_out=0; returns to IDLE (in_ready=1) the next cycle.
- a=3, b=5 → diff=0xFE, borrow_out=1. Also a=0x00, b=0x01 → diff=0xFF, borrow_out=1. Also a=0xAA, b=0xAA → diff=0x00, borrow_out=0.
- Backpressure: a=0x80, b=0x01, hold out_ready=0 for 5 cycles in DONE → diff=0x7F and borrow_out=0 stable, out_valid stays 1. Raise out_ready → one handshake, then IDLE.
- Ignored inputs: in_valid held high with changing a/b throughout RUN and DONE → result matches the operands latched at accept; no second accept until IDLE.
- Reset mid-operation: rst=1 at RUN cycle 4 → next cycle IDLE, in_ready=1, out_valid=0, diff=0, borrow_out=0. A subsequent 9−4 operation gives diff=0x05.
- Random regression: 1000 random unsigned a, b pairs with random out_ready stalls → diff==(a−b) mod 256 and borrow_out==(a<b) on every handshake.

Source files
------------

// File: rtl/serial_half_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor and its future adder sibling.
package serial_half_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEFAULT = 8;

  // Bit count needed to index W serial steps (0..W-1).
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the bit borrows.
module full_subtractor_cell (
  input  logic a_bit,
  input  logic b_bit,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a_bit ^ b_bit ^ bin;
  assign bout = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bin);

endmodule

// File: rtl/serial_half_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first through one cell, W cycles per operation.
module serial_half_subtractor
  import serial_half_subtractor_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  state_t         state_reg, state_next;
  logic [W-1:0]   sa_reg, sb_reg, diff_reg;
  logic           br_reg;
  logic [CW-1:0]  count_reg;
  logic           cell_d, cell_bout;

  full_subtractor_cell u_cell (
    .a_bit (sa_reg[0]),
    .b_bit (sb_reg[0]),
    .bin   (br_reg),
    .d     (cell_d),
    .bout  (cell_bout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (count_reg == LAST) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Results are gated by state so nothing but registers ever reaches the outputs.
  always_comb begin
    in_ready   = (state_reg == IDLE);
    out_valid  = (state_reg == DONE);
    diff       = (state_reg == DONE) ? diff_reg : '0;
    borrow_out = (state_reg == DONE) & br_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_reg    <= '0;
      sb_reg    <= '0;
      diff_reg  <= '0;
      br_reg    <= 1'b0;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            sa_reg    <= a;
            sb_reg    <= b;
            diff_reg  <= '0;
            br_reg    <= 1'b0;
            count_reg <= '0;
          end
        end
        RUN: begin
          diff_reg <= {cell_d, diff_reg[W-1:1]};
          sa_reg   <= sa_reg >> 1;
          sb_reg   <= sb_reg >> 1;
          br_reg   <= cell_bout;
          // Hold at the final index rather than wrapping; the FSM leaves RUN here anyway.
          if (count_reg != LAST) count_reg <= count_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_half_subtractor.sv
// Self-checking bench for serial_half_subtractor (W=8) against an arithmetic reference model.
module tb_serial_half_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_half_subtractor #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int d;
    d = int'(x) - int'(y);
    return W'((d + (1 << W)) % (1 << W));
  endfunction

  function automatic logic model_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return (int'(x) < int'(y));
  endfunction

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv);
    in_valid = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++; if (diff !== 8'h00) begin failures++; $display("FAIL reset_diff: got %02h want 00", diff); end
    checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL reset_borrow: got %0b want 0", borrow_out); end
    $display("txn reset done");
  endtask

  task automatic test_latency();
    int n;
    out_ready = 1'b1;
    accept(8'd5, 8'd3);
    a = '0; b = '0;
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      checks++; if (in_ready !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
        failures++; $display("FAIL run_outputs: got in_ready=%0b diff=%02h borrow=%0b want 0/00/0", in_ready, diff, borrow_out);
      end
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != W) begin failures++; $display("FAIL latency: got %0d edges want %0d", n, W); end
    checks++; if (diff !== 8'h02) begin failures++; $display("FAIL lat_diff: got %02h want 02", diff); end
    checks++; if (borrow_out !== 1'b0) begin failures++; $display("FAIL lat_borrow: got %0b want 0", borrow_out); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL done_in_ready: got %0b want 0", in_ready); end
    $display("txn a=05 b=03 diff=%02h borrow=%0b latency=%0d", diff, borrow_out, n);
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL lat_return_idle: got in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_boundaries();
    logic [W-1:0] ta [4] = '{8'h03, 8'h00, 8'hAA, 8'h00};
    logic [W-1:0] tb_ [4] = '{8'h05, 8'h01, 8'hAA, 8'hFF};
    int n;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      accept(ta[i], tb_[i]);
      wait_valid(n);
      checks++; if (n != W) begin failures++; $display("FAIL bnd_latency[%0d]: got %0d want %0d", i, n, W); end
      checks++; if (diff !== model_diff(ta[i], tb_[i])) begin
        failures++; $display("FAIL bnd_diff[%0d]: got %02h want %02h", i, diff, model_diff(ta[i], tb_[i]));
      end
      checks++; if (borrow_out !== model_borrow(ta[i], tb_[i])) begin
        failures++; $display("FAIL bnd_borrow[%0d]: got %0b want %0b", i, borrow_out, model_borrow(ta[i], tb_[i]));
      end
      $display("txn a=%02h b=%02h diff=%02h borrow=%0b", ta[i], tb_[i], diff, borrow_out);
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bnd_idle[%0d]: got %0b want 1", i, in_ready); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    out_ready = 1'b0;
    accept(8'h80, 8'h01);
    wait_valid(n);
    checks++; if (n != W) begin failures++; $display("FAIL bp_latency: got %0d want %0d", n, W); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || diff !== 8'h7F || borrow_out !== 1'b0 || in_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold[%0d]: got valid=%0b diff=%02h borrow=%0b in_ready=%0b want 1/7f/0/0",
                             i, out_valid, diff, borrow_out, in_ready);
      end
      @(posedge clk); #1;
    end
    $display("txn a=80 b=01 diff=%02h borrow=%0b stalled=5", diff, borrow_out);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release: got out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_ignored_inputs();
    logic [W-1:0] a0, b0;
    a0 = W'($urandom); b0 = W'($urandom);
    out_ready = 1'b0;
    in_valid = 1'b1; a = a0; b = b0;
    @(posedge clk); #1;
    for (int i = 0; i < W + 4; i++) begin
      a = W'($urandom); b = W'($urandom);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ign_in_ready[%0d]: got %0b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ign_valid: got %0b want 1", out_valid); end
    checks++; if (diff !== model_diff(a0, b0) || borrow_out !== model_borrow(a0, b0)) begin
      failures++; $display("FAIL ign_result: got %02h/%0b want %02h/%0b", diff, borrow_out, model_diff(a0, b0), model_borrow(a0, b0));
    end
    $display("txn a=%02h b=%02h diff=%02h borrow=%0b (inputs churned)", a0, b0, diff, borrow_out);
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL ign_idle: got in_ready=%0b out_valid=%0b want 1/0", in_ready, out_valid);
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ign_no_accept: got %0b want 1", in_ready); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    out_ready = 1'b1;
    accept(8'h33, 8'h11);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || diff !== 8'h00 || borrow_out !== 1'b0) begin
      failures++; $display("FAIL midrst_state: got in_ready=%0b valid=%0b diff=%02h borrow=%0b want 1/0/00/0",
                           in_ready, out_valid, diff, borrow_out);
    end
    repeat (W + 2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_no_result: got %0b want 0", out_valid); end
    accept(8'd9, 8'd4);
    wait_valid(n);
    checks++; if (n != W) begin failures++; $display("FAIL midrst_latency: got %0d want %0d", n, W); end
    checks++; if (diff !== 8'h05 || borrow_out !== 1'b0) begin
      failures++; $display("FAIL midrst_result: got %02h/%0b want 05/0", diff, borrow_out);
    end
    $display("txn a=09 b=04 diff=%02h borrow=%0b (after reset abort)", diff, borrow_out);
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [W-1:0] av, bv, got_d;
    logic got_b;
    int n;
    bit done;
    for (int t = 0; t < 1000; t++) begin
      av = W'($urandom_range(0, 255));
      bv = W'($urandom_range(0, 255));
      got_d = '0; got_b = 1'b0;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rnd_ready[%0d]: got %0b want 1", t, in_ready); end
      accept(av, bv);
      n = 0; done = 1'b0;
      while (!done && n < 100) begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (out_valid === 1'b1) begin
          got_d = diff; got_b = borrow_out;
          checks++; if (diff !== model_diff(av, bv) || borrow_out !== model_borrow(av, bv)) begin
            failures++; $display("FAIL rnd_result[%0d]: a=%02h b=%02h got %02h/%0b want %02h/%0b",
                                 t, av, bv, diff, borrow_out, model_diff(av, bv), model_borrow(av, bv));
          end
          if (out_ready) done = 1'b1;
        end
        @(posedge clk); #1;
        n++;
      end
      checks++; if (!done) begin failures++; $display("FAIL rnd_timeout[%0d]: got no handshake want one within 100 cycles", t); end
      $display("txn %0d a=%02h b=%02h diff=%02h borrow=%0b", t, av, bv, got_d, got_b);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_boundaries();
    test_backpressure();
    test_ignored_inputs();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
